subparser_num_arg: RTL and testbench

Argument subparser that reads ASCII characters one at a time from the shared line reader and converts one signed decimal G-code argument (for example the `-123` after `X`) into a two's-complement value. The parent command parser drives it through the standard subparser handshake: trigger, done, rdy, success and newline, plus the reader pass-through signals rd_trigger, rd_done, rd_rdy and is_empty. It sits directly below the parent's argument-subparser connection and directly above the character reader.

---
 rtl/subparser_num_arg.sv | 182 ++++++++++++++++++
 tb/tb_subparser_num_arg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/subparser_num_arg.sv
// subparser_num_arg
//   Converts one signed decimal G-code argument (e.g. "-123") read one
//   character at a time from the line reader into a two's-complement value.
//
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   trigger           : start a parse (only honoured while rdy=1)
//   rdy               : idle, accepting triggers
//   done              : one-cycle pulse when the parse finishes
//   success           : last parse was valid (held until next trigger)
//   newline           : last parse consumed '\n' (held until next trigger)
//   value             : signed result, 0 on failure (held until next trigger)
//   rd_trigger        : one-cycle read request to the reader
//   rd_done, char_in  : reader strobe and the character it delivers
//   rd_rdy, is_empty  : reader can accept a request / reader exhausted
module subparser_num_arg #(
  parameter int NUM_BITS   = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trigger,
  input  logic                rd_done,
  input  logic                rd_rdy,
  input  logic                is_empty,
  input  logic [7:0]          char_in,
  output logic                rdy,
  output logic                done,
  output logic                success,
  output logic                newline,
  output logic [NUM_BITS-1:0] value,
  output logic                rd_trigger
);

  localparam int CW = $clog2(MAX_DIGITS + 2);
  localparam int AW = NUM_BITS + 4;
  localparam logic [AW-1:0] LIMIT = {{5{1'b0}}, {(NUM_BITS-1){1'b1}}};

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                sign_seen_q, sign_seen_d;
  logic                success_q, success_d;
  logic                newline_q, newline_d;
  logic [NUM_BITS-1:0] value_q, value_d;

  logic [AW-1:0]       acc_wide;
  logic [CW-1:0]       cnt_inc;
  logic                is_digit;
  logic                fin_go;
  logic                fin_ok;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    sign_seen_d = sign_seen_q;
    success_d   = success_q;
    newline_d   = newline_q;
    value_d     = value_q;
    rd_trigger  = 1'b0;
    fin_go      = 1'b0;
    fin_ok      = 1'b0;

    acc_wide = {4'b0000, acc_q} * AW'(10) + {{(AW-4){1'b0}}, char_in[3:0]};
    cnt_inc  = cnt_q + CW'(1);
    is_digit = (char_in >= CH_ZERO) && (char_in <= CH_NINE);

    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          acc_d       = '0;
          cnt_d       = '0;
          neg_d       = 1'b0;
          sign_seen_d = 1'b0;
          success_d   = 1'b0;
          newline_d   = 1'b0;
          value_d     = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // End-of-input takes priority over issuing another read.
        if (is_empty) begin
          fin_go = 1'b1;
          fin_ok = (cnt_q != '0);
        end else if (rd_rdy) begin
          rd_trigger = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rd_done) begin
          if (char_in == CH_SPACE) begin
            // Leading spaces are skipped; a space after a sign alone is an error.
            if (cnt_q != '0) begin
              fin_go = 1'b1;
              fin_ok = 1'b1;
            end else if (!sign_seen_q) begin
              state_d = S_REQ;
            end else begin
              fin_go = 1'b1;
            end
          end else if (char_in == CH_MINUS || char_in == CH_PLUS) begin
            if (cnt_q == '0 && !sign_seen_q) begin
              sign_seen_d = 1'b1;
              neg_d       = (char_in == CH_MINUS);
              state_d     = S_REQ;
            end else begin
              fin_go = 1'b1;
            end
          end else if (is_digit) begin
            if (cnt_inc > CW'(MAX_DIGITS) || acc_wide > LIMIT) begin
              fin_go = 1'b1;
            end else begin
              acc_d   = acc_wide[NUM_BITS-1:0];
              cnt_d   = cnt_inc;
              state_d = S_REQ;
            end
          end else if (char_in == CH_NL) begin
            newline_d = 1'b1;
            fin_go    = 1'b1;
            fin_ok    = (cnt_q != '0);
          end else begin
            fin_go = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Results are registered on entry to FIN so they are valid with done.
    if (fin_go) begin
      state_d   = S_FIN;
      success_d = fin_ok;
      value_d   = fin_ok ? (neg_q ? ('0 - acc_q) : acc_q) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      sign_seen_q <= 1'b0;
      success_q   <= 1'b0;
      newline_q   <= 1'b0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      sign_seen_q <= sign_seen_d;
      success_q   <= success_d;
      newline_q   <= newline_d;
      value_q     <= value_d;
    end
  end

  assign rdy     = (state_q == S_IDLE);
  assign done    = (state_q == S_FIN);
  assign success = success_q;
  assign newline = newline_q;
  assign value   = value_q;

endmodule

// File: tb/tb_subparser_num_arg.sv
// Testbench for subparser_num_arg: a reader model serves a string at full
// rate; a driver issues directed vectors and pushes expectations, and a
// monitor pops and compares whenever done is seen.
module tb_subparser_num_arg;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic        rd_done;
  logic        rd_rdy;
  logic        is_empty;
  logic [7:0]  char_in;
  logic        rdy;
  logic        done;
  logic        success;
  logic        newline;
  logic [15:0] value;
  logic        rd_trigger;

  subparser_num_arg #(.NUM_BITS(16), .MAX_DIGITS(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .rd_done    (rd_done),
    .rd_rdy     (rd_rdy),
    .is_empty   (is_empty),
    .char_in    (char_in),
    .rdy        (rdy),
    .done       (done),
    .success    (success),
    .newline    (newline),
    .value      (value),
    .rd_trigger (rd_trigger)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reader model
  string vec_str = "";
  int    vec_len = 0;
  bit    empty_end = 1'b0;
  int    rd_idx;

  assign is_empty = empty_end && (rd_idx >= vec_len);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_done <= 1'b0;
      rd_idx  <= 0;
      char_in <= 8'h00;
    end else begin
      rd_done <= 1'b0;
      if (trigger && rdy) begin
        rd_idx <= 0;
      end else if (rd_trigger) begin
        char_in <= vec_str[rd_idx];
        rd_done <= 1'b1;
        rd_idx  <= rd_idx + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic [15:0] value;
    logic        succ;
    logic        nl;
    int          reads;
    int          lat;
    int          t;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [15:0] v_hold;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, ".value"},   32'(value),   32'(e.value));
          chk({e.name, ".success"}, 32'(success), 32'(e.succ));
          chk({e.name, ".newline"}, 32'(newline), 32'(e.nl));
          chk({e.name, ".reads"},   32'(rd_idx),  32'(e.reads));
          chk({e.name, ".latency"}, 32'(cyc - e.t), 32'(e.lat));
          chk({e.name, ".rdy_in_fin"}, 32'(rdy), 32'd0);
          v_hold = value;
          @(negedge clk);
          chk({e.name, ".rdy_after"}, 32'(rdy), 32'd1);
          chk({e.name, ".done_pulse"}, 32'(done), 32'd0);
          chk({e.name, ".value_held"}, 32'(value), 32'(v_hold));
        end
      end
    end
  end

  task automatic run_vec(input string s, input bit emp, input logic [15:0] v,
                         input bit sc, input bit nl, input int reads,
                         input int lat, input bit busy);
    exp_t e;
    int n;
    n = 0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({s, ".rdy_wait"}, 32'(rdy), 32'd1);
    vec_str   = s;
    vec_len   = s.len();
    empty_end = emp;
    e.name  = s;
    e.value = v;
    e.succ  = sc;
    e.nl    = nl;
    e.reads = reads;
    e.lat   = lat;
    e.t     = cyc;
    exp_q.push_back(e);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    if (busy) begin
      repeat (2) @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk({s, ".timeout"}, 32'd1, 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    int stray;
    reset   = 1'b1;
    trigger = 1'b0;
    rd_rdy  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.rdy",        32'(rdy),        32'd1);
    chk("rst.done",       32'(done),       32'd0);
    chk("rst.success",    32'(success),    32'd0);
    chk("rst.newline",    32'(newline),    32'd0);
    chk("rst.value",      32'(value),      32'd0);
    chk("rst.rd_trigger", 32'(rd_trigger), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //       string      emp  value     sc nl rd lat busy
    run_vec("-123 ",     0, 16'hFF85, 1, 0, 5, 11, 0);
    run_vec("42\n",      0, 16'h002A, 1, 1, 3, 7,  1);
    run_vec("  +7 ",     0, 16'h0007, 1, 0, 5, 11, 0);
    run_vec("-\n",       0, 16'h0000, 0, 1, 2, 5,  0);
    run_vec("12a",       0, 16'h0000, 0, 0, 3, 7,  0);
    run_vec("32768 ",    0, 16'h0000, 0, 0, 5, 11, 0);
    run_vec("32767 ",    0, 16'h7FFF, 1, 0, 6, 13, 0);
    run_vec("-32767\n",  0, 16'h8001, 1, 1, 7, 15, 0);
    run_vec("000001 ",   0, 16'h0000, 0, 0, 6, 13, 0);
    run_vec("5",         1, 16'h0005, 1, 0, 1, 4,  0);
    run_vec("",          1, 16'h0000, 0, 0, 0, 2,  0);
    run_vec("1-",        0, 16'h0000, 0, 0, 2, 5,  0);

    // Reset while waiting for a character
    vec_str   = "-123 ";
    vec_len   = 5;
    empty_end = 1'b0;
    trigger   = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    n = 0;
    while (!rd_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid.in_wait", 32'(rd_done), 32'd1);
    chk("mid.busy",    32'(rdy),     32'd0);
    reset = 1'b1;
    #1;
    chk("mid.rdy",        32'(rdy),        32'd1);
    chk("mid.done",       32'(done),       32'd0);
    chk("mid.success",    32'(success),    32'd0);
    chk("mid.newline",    32'(newline),    32'd0);
    chk("mid.value",      32'(value),      32'd0);
    chk("mid.rd_trigger", 32'(rd_trigger), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_trigger || done) stray++;
    end
    chk("mid.no_stray", 32'(stray), 32'd0);
    chk("mid.rdy_idle", 32'(rdy),   32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
